// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: directions, PS/2 make codes, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_MOVE = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  localparam logic [7:0] KEY_UP    = 8'h1D;
  localparam logic [7:0] KEY_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h23;

  typedef struct packed {
    logic vld;
    dir_e dir;
  } key_dec_t;

  // Map a make code to a direction; vld=0 for codes the game does not use.
  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t r;
    r.vld = 1'b1;
    r.dir = DIR_RIGHT;
    case (code)
      KEY_UP:    r.dir = DIR_UP;
      KEY_DOWN:  r.dir = DIR_DOWN;
      KEY_LEFT:  r.dir = DIR_LEFT;
      KEY_RIGHT: r.dir = DIR_RIGHT;
      default:   r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // Opposite pairs differ only in bit 0 with this encoding.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Three-digit BCD score counter, clear has priority over increment, saturates at 999.
// Latency: 1 cycle from inc_i/clr_i to bcd_o.
// Backpressure: none; every inc_i pulse is applied unless already at 999.
// Ports: clock/reset (sync, active-high), clr_i, inc_i, bcd_o = {hundreds, tens, units}.
module bcd_score_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [11:0] bcd_o
);

  logic [3:0] d0_q, d1_q, d2_q;
  logic [3:0] d0_d, d1_d, d2_d;
  logic       at_max;

  assign at_max = (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    if (clr_i) begin
      d0_d = 4'd0;
      d1_d = 4'd0;
      d2_d = 4'd0;
    end else if (inc_i && !at_max) begin
      if (d0_q != 4'd9) begin
        d0_d = d0_q + 4'd1;
      end else begin
        d0_d = 4'd0;
        if (d1_q != 4'd9) begin
          d1_d = d1_q + 4'd1;
        end else begin
          d1_d = 4'd0;
          d2_d = d2_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d0_q <= 4'd0;
      d1_q <= 4'd0;
      d2_q <= 4'd0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign bcd_o = {d2_q, d1_q, d0_q};

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control: move tick, step handshake to body datapath, direction keys, apple/score.
// Latency: shift_req rises the cycle MOVE is entered (one clock after the tick); outputs registered.
// Backpressure: a step waits in MOVE for shift_done; ticks during MOVE are dropped; apple_req holds to apple_ack.
// Ports: clock/reset; start_n, key_valid/key_code, good_hit/bad_hit in; shift_req/dir/grow + shift_done
//        step handshake; size; apple_req/apple_ack handshake; score_bcd; game_over.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV  = 4777777,
  parameter int MAX_LEN   = 128,
  parameter int START_LEN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        good_hit,
  input  logic        bad_hit,
  output logic        shift_req,
  input  logic        shift_done,
  output logic [1:0]  dir,
  output logic        grow,
  output logic [6:0]  size,
  output logic        apple_req,
  input  logic        apple_ack,
  output logic [11:0] score_bcd,
  output logic        game_over
);

  // size is a 7-bit count, so the length ceiling can never exceed 127.
  localparam int              SIZE_MAX  = (MAX_LEN > 127) ? 127 : MAX_LEN;
  localparam logic [6:0]      SIZE_CAP  = 7'(SIZE_MAX);
  localparam logic [6:0]      SIZE_INIT = 7'(START_LEN);
  localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  dir_e             next_dir_q, next_dir_d;
  logic             grow_q, grow_d;
  logic             grow_pend_q, grow_pend_d;
  logic             armed_q, armed_d;
  logic             apple_req_q, apple_req_d;
  logic [6:0]       size_q, size_d;

  key_dec_t key_dec;
  logic     active, tick, start_game, move_entry, move_done, hit_acc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    next_dir_d  = next_dir_q;
    grow_d      = grow_q;
    grow_pend_d = grow_pend_q;
    armed_d     = armed_q;
    apple_req_d = apple_req_q;
    size_d      = size_q;

    key_dec    = decode_key(key_code);
    active     = (state_q == ST_RUN) || (state_q == ST_MOVE);
    tick       = active && (cnt_q == CNT_LAST);
    start_game = (state_q == ST_IDLE) && !start_n;
    move_entry = (state_q == ST_RUN) && tick && !bad_hit;
    move_done  = (state_q == ST_MOVE) && shift_done && !bad_hit;
    // One apple per step: armed at MOVE entry, disarmed by the first accepted hit.
    hit_acc    = active && good_hit && !bad_hit && armed_q;

    case (state_q)
      ST_IDLE: if (!start_n) state_d = ST_RUN;
      ST_RUN: begin
        if (bad_hit)   state_d = ST_OVER;
        else if (tick) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (bad_hit)         state_d = ST_OVER;
        else if (shift_done) state_d = ST_RUN;
      end
      ST_OVER: if (!start_n) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (active) cnt_d = tick ? '0 : cnt_q + 1'b1;

    if (key_valid && key_dec.vld && (key_dec.dir != opposite(dir_q))) begin
      next_dir_d = key_dec.dir;
    end

    if (hit_acc) armed_d = 1'b0;

    if (move_entry) begin
      // Uses next_dir_d so a key arriving on the entry edge still counts as the last key.
      dir_d       = next_dir_d;
      grow_d      = grow_pend_q && (size_q < SIZE_CAP);
      grow_pend_d = 1'b0;
      armed_d     = 1'b1;
    end else if ((state_q == ST_MOVE) && (state_d != ST_MOVE)) begin
      grow_d = 1'b0;
    end

    // A hit on the entry edge belongs to the following step.
    if (hit_acc) grow_pend_d = 1'b1;

    if (move_done && grow_q && (size_q < SIZE_CAP)) size_d = size_q + 7'd1;

    if (apple_req_q && apple_ack) apple_req_d = 1'b0;
    if (hit_acc)                  apple_req_d = 1'b1;

    if (start_game) begin
      cnt_d       = '0;
      dir_d       = DIR_RIGHT;
      next_dir_d  = DIR_RIGHT;
      grow_d      = 1'b0;
      grow_pend_d = 1'b0;
      armed_d     = 1'b0;
      apple_req_d = 1'b1;
      size_d      = SIZE_INIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      grow_q      <= 1'b0;
      grow_pend_q <= 1'b0;
      armed_q     <= 1'b0;
      apple_req_q <= 1'b0;
      size_q      <= SIZE_INIT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      next_dir_q  <= next_dir_d;
      grow_q      <= grow_d;
      grow_pend_q <= grow_pend_d;
      armed_q     <= armed_d;
      apple_req_q <= apple_req_d;
      size_q      <= size_d;
    end
  end

  bcd_score_counter u_score (
    .clock (clock),
    .reset (reset),
    .clr_i (start_game),
    .inc_i (hit_acc),
    .bcd_o (score_bcd)
  );

  assign shift_req = (state_q == ST_MOVE);
  assign dir       = dir_q;
  assign grow      = grow_q;
  assign size      = size_q;
  assign apple_req = apple_req_q;
  assign game_over = (state_q == ST_OVER);

endmodule
